// File: rtl/ni_initiator_req_packetizer.sv
// Request-path packetizer for the CLUSTER_1 NI initiator: looks up the route for one
// OCP-style request, then emits a header flit and any write payload flits to the first-hop switch.
module ni_initiator_req_packetizer #(
   parameter int                   FLIT_WIDTH  = 80,
   parameter int                   PATH_WIDTH  = 7,
   parameter int                   TGT_WIDTH   = 4,
   parameter logic [TGT_WIDTH-1:0] SRC_ID      = 4'h1,
   parameter int                   BURST_WIDTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [2:0]             req_cmd,
   input  logic [31:0]            req_addr,
   input  logic [BURST_WIDTH-1:0] req_burst,
   input  logic                   wr_valid,
   output logic                   wr_ready,
   input  logic [31:0]            wr_data,
   input  logic [3:0]             wr_be,
   output logic [31:0]            lut_address,
   input  logic [PATH_WIDTH-1:0]  lut_path,
   input  logic [TGT_WIDTH-1:0]   lut_target,
   input  logic                   lut_failed,
   output logic [FLIT_WIDTH-1:0]  flit_out,
   output logic                   flit_valid,
   input  logic                   flit_ack,
   output logic                   err_valid,
   output logic [31:0]            err_addr
);

   localparam int HDR_PAD = FLIT_WIDTH - 2 - 32 - BURST_WIDTH - 3 - 2 * TGT_WIDTH - PATH_WIDTH;
   localparam int PAY_PAD = FLIT_WIDTH - 1 - 36;
   localparam logic [2:0] CMD_WRITE = 3'd1;
   localparam logic [2:0] CMD_READ  = 3'd2;

   typedef enum logic [2:0] {IDLE, LOOKUP, PAYLOAD, LAST, DRAIN} state_t;

   state_t                 state;
   state_t                 state_next;
   logic [2:0]             cmd_q;
   logic [BURST_WIDTH-1:0] burst_q;
   logic [BURST_WIDTH-1:0] beat_cnt;
   logic [31:0]            err_addr_q;
   logic                   cmd_write;
   logic                   cmd_legal;
   logic                   lookup_err;
   logic                   last_beat;
   logic                   req_fire;
   logic                   beat_fire;
   logic [FLIT_WIDTH-1:0]  header_flit;
   logic [FLIT_WIDTH-1:0]  payload_flit;

   assign cmd_write  = (cmd_q == CMD_WRITE);
   assign cmd_legal  = cmd_write || (cmd_q == CMD_READ);
   assign lookup_err = lut_failed || !cmd_legal;
   assign last_beat  = (beat_cnt == burst_q - BURST_WIDTH'(1));
   assign req_fire   = req_valid && req_ready;
   assign beat_fire  = wr_valid && wr_ready;

   // Reads are single-flit packets, so their header is also the tail
   assign header_flit  = {!cmd_write, 1'b1, {HDR_PAD{1'b0}}, lut_address, burst_q, cmd_q,
                          SRC_ID, lut_target, lut_path};
   assign payload_flit = {last_beat, {PAY_PAD{1'b0}}, wr_be, wr_data};

   // The failing address is visible in the same cycle as the error pulse, then held
   assign err_addr = err_valid ? lut_address : err_addr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake outputs; req_ready is gated by rst_n so every output reads 0 in reset
   always_comb begin
      state_next = state;
      req_ready  = 1'b0;
      wr_ready   = 1'b0;
      err_valid  = 1'b0;
      case (state)
         IDLE: begin
            req_ready = rst_n;
            if (req_valid) begin
               state_next = LOOKUP;
            end
         end
         LOOKUP: begin
            if (lookup_err) begin
               err_valid  = 1'b1;
               state_next = cmd_write ? DRAIN : IDLE;
            end else begin
               state_next = cmd_write ? PAYLOAD : LAST;
            end
         end
         PAYLOAD: begin
            wr_ready = !flit_valid || flit_ack;
            if (wr_valid && (!flit_valid || flit_ack) && last_beat) begin
               state_next = LAST;
            end
         end
         LAST: begin
            if (flit_ack) begin
               state_next = IDLE;
            end
         end
         DRAIN: begin
            wr_ready = 1'b1;
            if (wr_valid && last_beat) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // A beat consumed while the previous flit is acked overwrites it directly, so no bubble appears
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lut_address <= '0;
         cmd_q       <= '0;
         burst_q     <= '0;
         beat_cnt    <= '0;
         flit_out    <= '0;
         flit_valid  <= 1'b0;
         err_addr_q  <= '0;
      end else begin
         if (req_fire) begin
            lut_address <= req_addr;
            cmd_q       <= req_cmd;
            burst_q     <= (req_burst == '0) ? BURST_WIDTH'(1) : req_burst;
            beat_cnt    <= '0;
         end
         if (state == LOOKUP) begin
            if (lookup_err) begin
               err_addr_q <= lut_address;
            end else begin
               flit_out   <= header_flit;
               flit_valid <= 1'b1;
            end
         end else if (state == PAYLOAD && beat_fire) begin
            flit_out   <= payload_flit;
            flit_valid <= 1'b1;
            beat_cnt   <= beat_cnt + BURST_WIDTH'(1);
         end else if (flit_ack) begin
            flit_valid <= 1'b0;
         end
         if (state == DRAIN && beat_fire) begin
            beat_cnt <= beat_cnt + BURST_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_ni_initiator_req_packetizer.sv
// Scoreboard bench for the NI initiator request packetizer: stimulus pushes expected flits and
// errors, a negedge monitor pops and compares them as the DUT presents them.
module tb_ni_initiator_req_packetizer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_cmd;
   logic [31:0] req_addr;
   logic [3:0]  req_burst;
   logic        wr_valid;
   logic        wr_ready;
   logic [31:0] wr_data;
   logic [3:0]  wr_be;
   logic [31:0] lut_address;
   logic [6:0]  lut_path;
   logic [3:0]  lut_target;
   logic        lut_failed;
   logic [79:0] flit_out;
   logic        flit_valid;
   logic        flit_ack;
   logic        err_valid;
   logic [31:0] err_addr;

   int          tests = 0;
   int          fails = 0;
   logic [79:0] exp_flits[$];
   logic [31:0] exp_errs[$];
   logic        prev_hold = 1'b0;
   logic [79:0] prev_flit = '0;

   ni_initiator_req_packetizer dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
      .req_addr(req_addr), .req_burst(req_burst),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_be(wr_be),
      .lut_address(lut_address), .lut_path(lut_path), .lut_target(lut_target),
      .lut_failed(lut_failed),
      .flit_out(flit_out), .flit_valid(flit_valid), .flit_ack(flit_ack),
      .err_valid(err_valid), .err_addr(err_addr)
   );

   always #5 clk = ~clk;

   // CLUSTER_1 initiator routing table, combinational on lut_address
   always_comb begin
      lut_path   = 7'd0;
      lut_target = 4'd0;
      lut_failed = 1'b0;
      if (lut_address >= 32'h1000_0000 && lut_address < 32'h1080_0000) begin
         lut_path = 7'b0000000; lut_target = 4'h1;
      end else if (lut_address >= 32'h1080_0000 && lut_address < 32'h10C0_0000) begin
         lut_path = 7'b0000011; lut_target = 4'h8;
      end else if (lut_address >= 32'h10C0_0000 && lut_address < 32'h1100_0000) begin
         lut_path = 7'b0000010; lut_target = 4'hB;
      end else if (lut_address >= 32'h1A00_0000 && lut_address < 32'h1B00_0000) begin
         lut_path = 7'b0000111; lut_target = 4'hC;
      end else begin
         lut_failed = 1'b1;
      end
   end

   function automatic logic [79:0] makeHeader(input logic [2:0] cmd, input logic [3:0] beff,
                                              input logic [31:0] addr, input logic [6:0] path,
                                              input logic [3:0] tgt, input logic tail);
      return {tail, 1'b1, 24'h0, addr, beff, cmd, 4'h1, tgt, path};
   endfunction

   function automatic logic [79:0] makePayload(input logic [31:0] data, input logic [3:0] be,
                                               input logic tail);
      return {tail, 43'h0, be, data};
   endfunction

   task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic timeoutFail(input string name);
      tests++;
      fails++;
      $display("[TB] FAIL %s: timed out waiting for DUT", name);
   endtask

   // Issues one request and queues what it should produce; returns one cycle after acceptance
   task automatic applyStimulus(input logic [2:0] cmd, input logic [31:0] addr,
                                input logic [3:0] burst, input logic [6:0] path,
                                input logic [3:0] tgt, input logic expect_err);
      logic [3:0] beff;
      int         waited;
      beff = (burst == 4'd0) ? 4'd1 : burst;
      @(posedge clk);
      #1;
      if (expect_err) exp_errs.push_back(addr);
      else exp_flits.push_back(makeHeader(cmd, beff, addr, path, tgt, cmd == 3'd2));
      req_valid = 1'b1;
      req_cmd   = cmd;
      req_addr  = addr;
      req_burst = burst;
      waited    = 0;
      @(negedge clk);
      while (!req_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!req_ready) timeoutFail("req_accept");
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic sendBeats(input int n, input logic [31:0] base, input logic [3:0] beff,
                            input logic push);
      int waited;
      @(posedge clk);
      #1;
      for (int i = 0; i < n; i++) begin
         wr_valid = 1'b1;
         wr_data  = base + 32'(i);
         wr_be    = 4'hF ^ 4'(i);
         if (push) exp_flits.push_back(makePayload(wr_data, wr_be, 4'(i) == beff - 4'd1));
         waited = 0;
         @(negedge clk);
         while (!wr_ready && waited < 50) begin
            @(negedge clk);
            waited++;
         end
         if (!wr_ready) timeoutFail("wr_beat");
         @(posedge clk);
         #1;
      end
      wr_valid = 1'b0;
   endtask

   task automatic waitIdle();
      int waited = 0;
      @(negedge clk);
      while (!req_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("back_to_idle", 80'(req_ready), 80'(1));
   endtask

   // Monitor: flit stability while stalled, flit and error scoreboard
   always @(negedge clk) begin
      if (rst_n) begin
         if (prev_hold) begin
            checkOutput("stall_valid", 80'(flit_valid), 80'(1));
            checkOutput("stall_flit", flit_out, prev_flit);
         end
         if (flit_valid && flit_ack) begin
            if (exp_flits.size() == 0) timeoutFail("unexpected_flit");
            else checkOutput("flit", flit_out, exp_flits.pop_front());
         end
         if (err_valid) begin
            if (exp_errs.size() == 0) timeoutFail("unexpected_err");
            else checkOutput("err_addr", 80'(err_addr), 80'(exp_errs.pop_front()));
         end
      end
      prev_hold <= rst_n && flit_valid && !flit_ack;
      prev_flit <= flit_out;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [79:0] hdr;
      rst_n = 1'b0; req_valid = 1'b0; req_cmd = '0; req_addr = '0; req_burst = '0;
      wr_valid = 1'b0; wr_data = '0; wr_be = '0; flit_ack = 1'b1;
      #1;
      checkOutput("rst_req_ready", 80'(req_ready), 80'(0));
      checkOutput("rst_flit_valid", 80'(flit_valid), 80'(0));
      checkOutput("rst_lut_address", 80'(lut_address), 80'(0));
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      $display("[TB] read 0x10000004 burst 0");
      applyStimulus(3'd2, 32'h1000_0004, 4'd0, 7'b0000000, 4'h1, 1'b0);
      @(negedge clk);
      checkOutput("t1_lookup_valid", 80'(flit_valid), 80'(0));
      checkOutput("t1_lookup_ready", 80'(req_ready), 80'(0));
      checkOutput("t1_lut_address", 80'(lut_address), 80'(32'h1000_0004));
      @(negedge clk);
      checkOutput("t1_hdr_cycle2", 80'(flit_valid), 80'(1));
      @(negedge clk);
      checkOutput("t1_ready_after_ack", 80'(req_ready), 80'(1));

      $display("[TB] write 0x1A000010 burst 4");
      applyStimulus(3'd1, 32'h1A00_0010, 4'd4, 7'b0000111, 4'hC, 1'b0);
      sendBeats(4, 32'hA0, 4'd4, 1'b1);
      waitIdle();

      $display("[TB] stalled header on write 0x10C00000");
      flit_ack = 1'b0;
      applyStimulus(3'd1, 32'h10C0_0000, 4'd1, 7'b0000010, 4'hB, 1'b0);
      wr_valid = 1'b1; wr_data = 32'h5555_0001; wr_be = 4'hC;
      exp_flits.push_back(makePayload(32'h5555_0001, 4'hC, 1'b1));
      hdr = makeHeader(3'd1, 4'd1, 32'h10C0_0000, 7'b0000010, 4'hB, 1'b0);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("t3_stall_flit", flit_out, hdr);
         checkOutput("t3_stall_wr_ready", 80'(wr_ready), 80'(0));
      end
      @(posedge clk);
      #1 flit_ack = 1'b1;
      @(negedge clk);
      checkOutput("t3_wr_ready_on_ack", 80'(wr_ready), 80'(1));
      @(posedge clk);
      #1 wr_valid = 1'b0;
      @(negedge clk);
      checkOutput("t3_no_bubble", 80'(flit_valid), 80'(1));
      waitIdle();

      $display("[TB] undecodable write 0x20000000 then read 0x10800000");
      applyStimulus(3'd1, 32'h2000_0000, 4'd2, 7'd0, 4'd0, 1'b1);
      @(negedge clk);
      checkOutput("t4_err_pulse", 80'(err_valid), 80'(1));
      checkOutput("t4_err_no_flit", 80'(flit_valid), 80'(0));
      sendBeats(2, 32'hD0, 4'd2, 1'b0);
      @(negedge clk);
      checkOutput("t4_drained_idle", 80'(req_ready), 80'(1));
      checkOutput("t4_err_single", 80'(err_valid), 80'(0));
      checkOutput("t4_err_addr_held", 80'(err_addr), 80'(32'h2000_0000));
      applyStimulus(3'd2, 32'h1080_0000, 4'd0, 7'b0000011, 4'h8, 1'b0);
      waitIdle();

      $display("[TB] illegal cmd 5");
      applyStimulus(3'd5, 32'h1000_0000, 4'd0, 7'd0, 4'd1, 1'b1);
      @(negedge clk);
      checkOutput("t5_err_pulse", 80'(err_valid), 80'(1));
      @(negedge clk);
      checkOutput("t5_idle", 80'(req_ready), 80'(1));
      checkOutput("t5_no_flit", 80'(flit_valid), 80'(0));

      $display("[TB] reset mid-burst");
      applyStimulus(3'd1, 32'h1A00_0010, 4'd4, 7'b0000111, 4'hC, 1'b0);
      sendBeats(2, 32'hB0, 4'd4, 1'b1);
      rst_n = 1'b0;
      #1;
      exp_flits.delete();
      checkOutput("t6_flit_valid", 80'(flit_valid), 80'(0));
      checkOutput("t6_flit_out", flit_out, 80'(0));
      checkOutput("t6_wr_ready", 80'(wr_ready), 80'(0));
      checkOutput("t6_req_ready", 80'(req_ready), 80'(0));
      checkOutput("t6_err_addr", 80'(err_addr), 80'(0));
      checkOutput("t6_lut_address", 80'(lut_address), 80'(0));
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      applyStimulus(3'd2, 32'h1080_0000, 4'd2, 7'b0000011, 4'h8, 1'b0);
      waitIdle();

      repeat (3) @(negedge clk);
      checkOutput("flits_left", 80'(exp_flits.size()), 80'(0));
      checkOutput("errs_left", 80'(exp_errs.size()), 80'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
